// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU execution controller: clock-enable strobes, IN/OUT handshakes, HALT, step mode
// One cpu_enable pulse per qualifying divider tick; IN/OUT wait on an operator press.
module cpu_run_ctrl #(
   parameter int          DATA_WIDTH    = 28,
   parameter int          SW_WIDTH      = 18,
   parameter int          CNT_WIDTH     = 32,
   parameter logic [31:0] BLANK_PATTERN = 32'h07FFFFFF
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  button,
   input  logic                  step_mode,
   input  logic                  op_in,
   input  logic                  op_out,
   input  logic                  op_halt,
   input  logic [DATA_WIDTH-1:0] cpu_display,
   input  logic [SW_WIDTH-1:0]   switches,
   output logic                  cpu_enable,
   output logic [SW_WIDTH-1:0]   in_data,
   output logic [31:0]           display_data,
   output logic                  halted,
   output logic [1:0]            state,
   output logic [CNT_WIDTH-1:0]  instr_count
);

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_WAIT_IO = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic button_q;
   logic step_req;
   logic io_is_in;
   logic press;
   logic run_plain_tick;
   logic enable_next;

   always_comb begin
      press          = button & ~button_q;
      run_plain_tick = tick & ~op_halt & ~op_in & ~op_out;
      enable_next    = 1'b0;
      case (state)
         ST_RUN:     enable_next = run_plain_tick & (~step_mode | step_req);
         ST_RELEASE: enable_next = tick;
         default:    enable_next = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_RUN;
         cpu_enable   <= 1'b0;
         in_data      <= '0;
         display_data <= BLANK_PATTERN;
         halted       <= 1'b0;
         instr_count  <= '0;
         step_req     <= 1'b0;
         button_q     <= 1'b0;
         io_is_in     <= 1'b0;
      end else begin
         button_q   <= button;
         cpu_enable <= enable_next;

         if (enable_next && (instr_count != '1))
            instr_count <= instr_count + CNT_ONE;

         // A fresh press wins over consuming the old request in the same cycle.
         if (!step_mode)
            step_req <= 1'b0;
         else if ((state == ST_RUN) && press)
            step_req <= 1'b1;
         else if ((state == ST_RUN) && enable_next)
            step_req <= 1'b0;

         case (state)
            ST_RUN: begin
               if (tick) begin
                  if (op_halt) begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                  end else if (op_in) begin
                     state    <= ST_WAIT_IO;
                     io_is_in <= 1'b1;
                  end else if (op_out) begin
                     state        <= ST_WAIT_IO;
                     io_is_in     <= 1'b0;
                     display_data <= {{(32-DATA_WIDTH){1'b0}}, cpu_display};
                  end
               end
            end
            ST_WAIT_IO: begin
               if (press) begin
                  state <= ST_RELEASE;
                  if (io_is_in)
                     in_data <= switches;
               end
            end
            ST_RELEASE: begin
               // Only reachable a cycle after the press, so a coincident tick never counts.
               if (tick) begin
                  state        <= ST_RUN;
                  display_data <= BLANK_PATTERN;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl
module tb_cpu_run_ctrl;
   localparam int          DW    = 28;
   localparam int          SW    = 18;
   localparam int          CW    = 32;
   localparam int          SCW   = 3;
   localparam logic [31:0] BLANK = 32'h07FFFFFF;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          tick = 1'b0, button = 1'b0, step_mode = 1'b0;
   logic          op_in = 1'b0, op_out = 1'b0, op_halt = 1'b0;
   logic [DW-1:0] cpu_display = '0;
   logic [SW-1:0] switches = '0;

   logic           cpu_enable, halted;
   logic [SW-1:0]  in_data;
   logic [31:0]    display_data;
   logic [1:0]     state;
   logic [CW-1:0]  instr_count;

   logic           s_enable, s_halted;
   logic [SW-1:0]  s_in_data;
   logic [31:0]    s_display;
   logic [1:0]     s_state;
   logic [SCW-1:0] s_count;

   int checks = 0;
   int errors = 0;
   int en_seen = 0;

   cpu_run_ctrl dut (
      .clock(clock), .reset(reset), .tick(tick), .button(button), .step_mode(step_mode),
      .op_in(op_in), .op_out(op_out), .op_halt(op_halt), .cpu_display(cpu_display),
      .switches(switches), .cpu_enable(cpu_enable), .in_data(in_data),
      .display_data(display_data), .halted(halted), .state(state), .instr_count(instr_count)
   );

   cpu_run_ctrl #(.CNT_WIDTH(SCW)) dut_small (
      .clock(clock), .reset(reset), .tick(tick), .button(button), .step_mode(step_mode),
      .op_in(op_in), .op_out(op_out), .op_halt(op_halt), .cpu_display(cpu_display),
      .switches(switches), .cpu_enable(s_enable), .in_data(s_in_data),
      .display_data(s_display), .halted(s_halted), .state(s_state), .instr_count(s_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode plus unbounded counter; display and halted derived from mode.
   int            m_mode;
   bit            m_prev_btn, m_req, m_kind_in, m_en;
   logic [DW-1:0] m_latch;
   logic [SW-1:0] m_in;
   longint        m_count;

   function automatic logic [31:0] exp_display();
      if ((m_mode == 1 || m_mode == 2) && !m_kind_in) return {{(32-DW){1'b0}}, m_latch};
      return BLANK;
   endfunction

   function automatic longint sat(input longint v, input int w);
      longint mx = (longint'(1) << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_mode = 0; m_prev_btn = 0; m_req = 0; m_kind_in = 0; m_en = 0;
         m_latch = '0; m_in = '0; m_count = 0;
      end else begin
         bit pr, en, nreq;
         int prev_mode;
         pr = button && !m_prev_btn;
         m_prev_btn = button;
         prev_mode = m_mode;
         en = 0;
         if (m_mode == 0 && tick) begin
            if (op_halt) m_mode = 3;
            else if (op_in) begin m_mode = 1; m_kind_in = 1; end
            else if (op_out) begin m_mode = 1; m_kind_in = 0; m_latch = cpu_display; end
            else en = !step_mode || m_req;
         end else if (m_mode == 1 && pr) begin
            m_mode = 2;
            if (m_kind_in) m_in = switches;
         end else if (m_mode == 2 && tick) begin
            m_mode = 0;
            en = 1;
         end
         nreq = m_req;
         if (prev_mode == 0 && step_mode && en) nreq = 0;
         if (prev_mode == 0 && step_mode && pr) nreq = 1;
         if (!step_mode) nreq = 0;
         m_req = nreq;
         m_en = en;
         if (en) m_count++;
      end
   end

   always @(negedge clock) begin
      check("cpu_enable", cpu_enable, m_en);
      check("state", state, m_mode[1:0]);
      check("display_data", display_data, exp_display());
      check("in_data", in_data, m_in);
      check("halted", halted, m_mode == 3);
      check("instr_count", instr_count, sat(m_count, CW));
      check("small_count", s_count, sat(m_count, SCW));
      check("small_enable", s_enable, m_en);
      check("small_outputs", {s_state, s_halted, s_display, s_in_data},
            {state, halted, display_data, in_data});
      if (cpu_enable === 1'b1) en_seen++;
   end

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic do_tick();
      tick = 1'b1; step(); tick = 1'b0; step(); step();
   endtask

   task automatic do_press();
      button = 1'b1; step(); button = 1'b0; step(); step();
   endtask

   task automatic tick_op(input logic h, input logic i, input logic o);
      op_halt = h; op_in = i; op_out = o; tick = 1'b1;
      step();
      op_halt = 1'b0; op_in = 1'b0; op_out = 1'b0; tick = 1'b0;
      step(); step();
   endtask

   int en0;

   initial begin
      step(); step();
      check("reset_state", state, 2'd0);
      check("reset_display", display_data, 32'h07FFFFFF);
      check("reset_count", instr_count, 0);
      reset = 1'b0;
      step();

      en0 = en_seen;
      repeat (5) do_tick();
      check("free_run_enables", en_seen - en0, 5);
      check("free_run_count", instr_count, 5);

      en0 = en_seen;
      tick_op(1'b0, 1'b1, 1'b0);
      check("in_wait_state", state, 2'd1);
      repeat (3) do_tick();
      check("in_no_enable_before_press", en_seen - en0, 0);
      switches = 18'h2A5A5;
      do_press();
      check("in_data_latched", in_data, 18'h2A5A5);
      check("in_release_state", state, 2'd2);
      do_tick();
      check("in_one_enable", en_seen - en0, 1);
      check("in_back_to_run", state, 2'd0);
      check("small_count_6", s_count, 6);

      en0 = en_seen;
      cpu_display = 28'h0000123;
      tick_op(1'b0, 1'b0, 1'b1);
      check("out_display", display_data, 32'h00000123);
      repeat (2) do_tick();
      switches = 18'h11111;
      button = 1'b1; tick = 1'b1; step();
      button = 1'b0; tick = 1'b0; step(); step();
      check("out_press_tick_no_enable", en_seen - en0, 0);
      check("out_release_display", display_data, 32'h00000123);
      do_tick();
      check("out_one_enable", en_seen - en0, 1);
      check("out_blank_after", display_data, 32'h07FFFFFF);
      check("in_data_held", in_data, 18'h2A5A5);
      check("small_count_7", s_count, 7);

      step_mode = 1'b1;
      step();
      en0 = en_seen;
      repeat (4) do_tick();
      check("step_no_press", en_seen - en0, 0);
      repeat (3) do_press();
      repeat (2) do_tick();
      check("step_one_enable", en_seen - en0, 1);
      check("count_8", instr_count, 8);
      check("small_saturated", s_count, 7);
      step_mode = 1'b0;
      step();

      en0 = en_seen;
      cpu_display = 28'hABCDEF0;
      tick_op(1'b0, 1'b0, 1'b1);
      do_press();
      check("abort_pre_state", state, 2'd2);
      check("abort_pre_display", display_data, 32'h0ABCDEF0);
      reset = 1'b1; tick = 1'b1; step();
      tick = 1'b0; step();
      check("abort_state", state, 2'd0);
      check("abort_display", display_data, 32'h07FFFFFF);
      check("abort_count", instr_count, 0);
      check("abort_no_enable", en_seen - en0, 0);
      reset = 1'b0;
      step();
      do_tick();
      check("after_abort_count", instr_count, 1);

      en0 = en_seen;
      tick_op(1'b1, 1'b1, 1'b0);
      check("halt_state", state, 2'd3);
      check("halt_flag", halted, 1'b1);
      repeat (3) do_tick();
      repeat (2) do_press();
      tick_op(1'b0, 1'b1, 1'b0);
      check("halt_no_enable", en_seen - en0, 0);
      check("halt_count_frozen", instr_count, 1);
      check("halt_sticky", state, 2'd3);
      check("halt_in_data", in_data, 18'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
